pc_register: RTL and testbench
==============================

Name: pc_register

Overview:
- 64-bit program-counter register at the head of the fetch stage.
- Each rising clock edge it captures the next-address value computed upstream (PC+4 adder / branch mux) in `nueva_direccion`.
- It drives the captured value as the fetch address to instruction memory on `salida_im`.
- Single clock domain; purely registered output, no combinational input-to-output path.

Parameters:
- ADDR_W, 64, width of the address path.
- RESET_ADDR, 64'h0, value loaded into the PC on reset.
- ALIGN_BITS, 2, number of low address bits that must be zero for a legal instruction address (4-byte instructions).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  synchronous active-low reset.
- stall  input  1  active-high hold; the PC keeps its value while asserted.
- nueva_direccion  input  ADDR_W  next PC value from the next-address logic.
- salida_im  output  ADDR_W  current PC, the instruction-memory fetch address.
- misalign_err  output  1  present only with PC_ALIGN_CHECK_EN; see Optional Feature.

Behaviour:
- All state updates occur on the rising edge of clk only; the falling edge has no effect.
- Priority at each rising edge:
  1. rst_n==0: salida_im <= RESET_ADDR.
  2. stall==1: salida_im holds its value.
  3. Otherwise: salida_im <= nueva_direccion.
- Reset is synchronous: asserting rst_n between edges has no effect until the next rising edge. Reset overrides stall.
- Latency is exactly 1 cycle from nueva_direccion to salida_im. Input changes between edges are never visible on the output.
- Before the first reset edge salida_im is undefined. Benches must apply reset before checking.
- No arithmetic is performed. The value is copied bit-exact; there is no wrap-around or increment logic inside this block.
- Misaligned addresses are loaded unchanged; the block never masks the low bits.
- Reset mid-operation: the next rising edge with rst_n==0 forces RESET_ADDR regardless of stall or nueva_direccion. The first edge after rst_n returns high loads nueva_direccion (or holds if stall==1).
- stall and a new nueva_direccion in the same cycle: the new address is ignored. Upstream must keep presenting it until stall deasserts.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds the registered output misalign_err.
  - On each rising edge that loads nueva_direccion (not reset, not stall), misalign_err <= |nueva_direccion[ALIGN_BITS-1:0].
  - Reset clears misalign_err to 0; stall holds it.
  - misalign_err is therefore always aligned in time with the salida_im value it describes.
- Not defined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pc_pkg holds:
  - ADDR_W default (64);
  - RESET_ADDR default (64'h0);
  - INSTR_BYTES (4) and the derived ALIGN_BITS;
  - typedef addr_t (logic [ADDR_W-1:0]), used by the fetch stage and the next-address logic.
- No sub-module: a single register process plus the optional check. The PC+4 adder and branch mux stay outside this block.

Test Plan:
- Reset: rst_n=0 for one rising edge with nueva_direccion=64'h4 -> salida_im=64'h0 after that edge. Release rst_n; next edge with 64'h4 -> salida_im=64'h4.
- Sequential load: present 64'h4, 64'h8, 64'hC on successive rising edges -> salida_im = 4, 8, C, each exactly one edge after presentation. Changing nueva_direccion to 64'h4 while clk is low between edges leaves salida_im at 8 until the next rising edge.
- Stall: salida_im=64'h8, stall=1, nueva_direccion=64'h10 for 3 edges -> salida_im stays 8. Deassert stall -> next edge salida_im=64'h10.
- Reset priority and synchronicity:
  - stall=1 and rst_n=0 on the same edge -> salida_im=64'h0.
  - rst_n pulsed low only between edges (not sampled) -> salida_im unchanged.
- Full-width passthrough: load 64'hFFFF_FFFF_FFFF_FFFC, then 64'h8000_0000_0000_0000 -> salida_im matches each value bit-exact.
- With PC_ALIGN_CHECK_EN:
  - load 64'h6 -> misalign_err=1 with salida_im=64'h6;
  - load 64'h8 -> misalign_err=0;
  - reset -> misalign_err=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared fetch-path definitions: address width, reset vector and
// instruction alignment. Used by the PC register, the fetch stage and
// the next-address logic.
package pc_pkg;

    localparam int ADDR_W = 64;
    localparam logic [ADDR_W-1:0] RESET_ADDR = 64'h0;

    // Instructions are fixed 4 bytes, so the low log2(4) bits of a legal
    // fetch address are zero.
    localparam int INSTR_BYTES = 4;
    localparam int ALIGN_BITS  = $clog2(INSTR_BYTES);

    typedef logic [ADDR_W-1:0] addr_t;

endpackage : pc_pkg

// File: rtl/pc_register.sv
// Program-counter register at the head of the fetch stage.
// Captures the upstream next-address value on each rising edge and drives
// it as the instruction-memory fetch address. Reset is synchronous and
// active-low and beats stall; stall holds the current PC.
// Optional: define PC_ALIGN_CHECK_EN to add the registered misalign_err
// flag, which travels in lockstep with the salida_im value it describes.
module pc_register #(
    parameter int                ADDR_W     = pc_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = pc_pkg::RESET_ADDR,
    parameter int                ALIGN_BITS = pc_pkg::ALIGN_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [ADDR_W-1:0] nueva_direccion,
    output logic [ADDR_W-1:0] salida_im
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic              misalign_err
`endif
);

    import pc_pkg::*;

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;

    // Next PC: hold while stalled, otherwise take the upstream address as-is
    // (no masking of low bits, no arithmetic).
    always_comb begin
        pc_next = pc_reg;
        if (!stall) begin
            pc_next = nueva_direccion;
        end
    end

    // PC state register; reset has priority over everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg <= RESET_ADDR;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign salida_im = pc_reg;

`ifdef PC_ALIGN_CHECK_EN
    logic [ALIGN_BITS-1:0] low_bits;
    logic                  misalign_reg;
    logic                  misalign_next;

    // Gather the address bits that must be zero for a legal fetch.
    generate
        for (genvar gi = 0; gi < ALIGN_BITS; gi++) begin : g_low_bits
            assign low_bits[gi] = nueva_direccion[gi];
        end
    endgenerate

    // Flag follows the same load/hold decision as the PC itself.
    always_comb begin
        misalign_next = misalign_reg;
        if (!stall) begin
            misalign_next = |low_bits;
        end
    end

    // Alignment flag register, cleared by reset alongside the PC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= misalign_next;
        end
    end

    assign misalign_err = misalign_reg;
`endif

endmodule : pc_register

// File: tb/tb_pc_register.sv
// Directed bench for pc_register: reset, sequential load, stall, reset
// priority/synchronicity, full-width passthrough and, when
// PC_ALIGN_CHECK_EN is defined, the misalignment flag.
module tb_pc_register;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [63:0] nueva_direccion;
    logic [63:0] salida_im;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int total = 0;
    int bad   = 0;

    pc_register dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .nueva_direccion (nueva_direccion),
        .salida_im       (salida_im)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_err    (misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when observed differs from expected.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%h", tag, got);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        stall           = 1'b0;
        nueva_direccion = 64'h4;

        // Reset for one edge, then release.
        step();
        check("reset_pc", salida_im, 64'h0);
`ifdef PC_ALIGN_CHECK_EN
        check("reset_err", {63'b0, misalign_err}, 64'h0);
`endif
        rst_n = 1'b1;
        step();
        check("first_load", salida_im, 64'h4);

        // Sequential load, plus an input change between edges.
        nueva_direccion = 64'h8;
        step();
        check("seq_8", salida_im, 64'h8);
        @(negedge clk);
        nueva_direccion = 64'h4;
        #1;
        check("mid_cycle_hold", salida_im, 64'h8);
        nueva_direccion = 64'hC;
        step();
        check("seq_c", salida_im, 64'hC);

        // Stall for three edges with a new address pending.
        nueva_direccion = 64'h8;
        step();
        check("pre_stall", salida_im, 64'h8);
        stall           = 1'b1;
        nueva_direccion = 64'h10;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_%0d", i), salida_im, 64'h8);
        end
        stall = 1'b0;
        step();
        check("stall_release", salida_im, 64'h10);

        // Reset beats stall.
        stall           = 1'b1;
        rst_n           = 1'b0;
        nueva_direccion = 64'h20;
        step();
        check("rst_over_stall", salida_im, 64'h0);
        rst_n           = 1'b1;
        stall           = 1'b0;
        nueva_direccion = 64'h24;
        step();
        check("post_rst_load", salida_im, 64'h24);

        // Reset pulse between edges is never sampled.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check("rst_glitch_now", salida_im, 64'h24);
        nueva_direccion = 64'h28;
        step();
        check("rst_glitch_next", salida_im, 64'h28);

        // Full-width passthrough.
        nueva_direccion = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        check("full_ones", salida_im, 64'hFFFF_FFFF_FFFF_FFFC);
        nueva_direccion = 64'h8000_0000_0000_0000;
        step();
        check("msb_only", salida_im, 64'h8000_0000_0000_0000);

        // Misaligned addresses pass through unmasked.
        nueva_direccion = 64'h6;
        step();
        check("misaligned_pc", salida_im, 64'h6);
`ifdef PC_ALIGN_CHECK_EN
        check("misaligned_err", {63'b0, misalign_err}, 64'h1);
        stall           = 1'b1;
        nueva_direccion = 64'h8;
        step();
        check("stall_err_hold", {63'b0, misalign_err}, 64'h1);
        stall = 1'b0;
`endif
        nueva_direccion = 64'h8;
        step();
        check("aligned_pc", salida_im, 64'h8);
`ifdef PC_ALIGN_CHECK_EN
        check("aligned_err", {63'b0, misalign_err}, 64'h0);
        nueva_direccion = 64'h3;
        step();
        check("err_set_again", {63'b0, misalign_err}, 64'h1);
        rst_n = 1'b0;
        step();
        check("rst_clears_err", {63'b0, misalign_err}, 64'h0);
        rst_n = 1'b1;
`endif

        // Final reset from a non-zero PC.
        nueva_direccion = 64'h1234;
        step();
        check("pre_final_rst", salida_im, 64'h1234);
        rst_n = 1'b0;
        step();
        check("final_rst", salida_im, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_register
